// File: rtl/bram_stream_reader.sv
// Burst read sequencer for the node-data BRAM: issues consecutive reads on start
// and re-streams the returned words through a small skid FIFO as valid/ready beats.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   rd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  input  logic                  bram_rd_data_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  state;
  logic [LW-1:0]           len_q, issued, delivered;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic                    push, pop, room;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check counts the outstanding read so a full FIFO can always absorb it;
  // it only looks at registers, keeping out_ready off the bram_re path.
  assign room      = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign bram_re   = ~rst & (state == S_READ) & room;
  assign push      = bram_rd_data_vld & inflight;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_last  = out_valid & ((delivered + LW'(1)) == len_q);

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= bram_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bram_rd_addr <= '0;
      len_q        <= '0;
      issued       <= '0;
      delivered    <= '0;
      inflight     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= bram_re;
      if (bram_re) begin
        bram_rd_addr <= (bram_rd_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : bram_rd_addr + ADDR_WIDTH'(1);
        issued       <= issued + LW'(1);
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        delivered <= delivered + LW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);

      case (state)
        S_IDLE: if (start) begin
          len_q        <= rd_len;
          bram_rd_addr <= base_addr;
          issued       <= '0;
          delivered    <= '0;
          if (rd_len == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_READ;
            busy  <= 1'b1;
          end
        end
        S_READ: if (bram_re && (issued + LW'(1)) == len_q) state <= S_DRAIN;
        // The last-beat pop implies every read has landed and the FIFO empties now.
        S_DRAIN: if (pop && out_last) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
